fetch_ctrl: RTL and testbench

Multicycle fetch/decode sequencer that drives the control inputs of the instruction unit (PC, instruction memory, IR) and consumes its IR output. It fetches one instruction per pass, decodes the opcode to resolve J/JAL and BREAK locally, then hands the instruction to the datapath and waits for completion. On completion it applies any branch or register redirect before the next fetch.

---
 rtl/fetch_ctrl_pkg.sv | 26 ++
 rtl/fetch_ctrl_opcode_classify.sv | 28 ++
 rtl/fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_fetch_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared state encoding and instruction-field constants for fetch_ctrl
package fetch_ctrl_pkg;

  // Sequencer states; RST_WAIT is the reset state and the encoding is otherwise arbitrary
  typedef enum logic [2:0] {
    ST_RST_WAIT = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_EXEC     = 3'd3,
    ST_HALT     = 3'd4
  } state_t;

  // Primary opcode field values (IR[31:26])
  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_JAL      = 6'b000011;

  // R-type function field (IR[5:0]) that stops the sequencer
  localparam logic [5:0] FUNCT_BREAK = 6'b001101;

  // PC source selects understood by the instruction unit
  localparam logic [1:0] PCSEL_BR    = 2'b00;  // PC + (sign-extended offset << 2)
  localparam logic [1:0] PCSEL_JMP   = 2'b01;  // jump target from IR[25:0]
  localparam logic [1:0] PCSEL_REG   = 2'b10;  // register target (jr)

endpackage

// File: rtl/fetch_ctrl_opcode_classify.sv
// rtl/fetch_ctrl_opcode_classify.sv - combinational classifier for instructions the sequencer resolves itself
module fetch_ctrl_opcode_classify
  import fetch_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output logic        is_j,
  output logic        is_jal,
  output logic        is_break
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode = ir[31:26];
  assign funct  = ir[5:0];

  // Register/immediate fields belong to the datapath and are not looked at here
  assign unused_fields = ^ir[25:6];

  // Only J, JAL and BREAK change sequencing; everything else goes to the datapath
  always_comb begin
    is_j     = (opcode == OP_J);
    is_jal   = (opcode == OP_JAL);
    is_break = (opcode == OP_RTYPE) && (funct == FUNCT_BREAK);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - multicycle fetch/decode sequencer; FETCH_PERF_CNT_EN adds the retired-instruction counter
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_in,
  input  logic        stall,
  input  logic        exec_done,
  input  logic        redirect,
  input  logic [1:0]  redirect_sel,
  output logic [1:0]  pc_sel,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        im_cs,
  output logic        im_rd,
  output logic        im_wr,
  output logic        ir_ld,
  output logic        ir_valid,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] retired
`endif
);

  state_t state_q;
  state_t state_d;

  logic is_j;
  logic is_jal;
  logic is_break;

  fetch_ctrl_opcode_classify u_opcode_classify (
    .ir       (IR_in),
    .is_j     (is_j),
    .is_jal   (is_jal),
    .is_break (is_break)
  );

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RST_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: J finishes in DECODE, BREAK parks in HALT, all else waits for the datapath
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST_WAIT: state_d = ST_FETCH;
      ST_FETCH: begin
        if (!stall) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (is_j)          state_d = ST_FETCH;
        else if (is_break) state_d = ST_HALT;
        else               state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (exec_done) state_d = ST_FETCH;
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RST_WAIT;
    endcase
  end

  // Control strobes; the fetch strobes IR and increments PC on the same edge, so a
  // later branch target is computed from PC+4. pc_ld and pc_inc live in different states.
  always_comb begin
    pc_sel   = PCSEL_BR;
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    im_cs    = 1'b0;
    im_rd    = 1'b0;
    im_wr    = 1'b0;
    ir_ld    = 1'b0;
    ir_valid = 1'b0;
    halted   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (!stall) begin
          im_cs  = 1'b1;
          im_rd  = 1'b1;
          ir_ld  = 1'b1;
          pc_inc = 1'b1;
        end
      end
      ST_DECODE: begin
        ir_valid = 1'b1;
        if (is_j || is_jal) begin
          pc_sel = PCSEL_JMP;
          pc_ld  = 1'b1;
        end
      end
      ST_EXEC: begin
        if (exec_done && redirect) begin
          pc_sel = redirect_sel;
          pc_ld  = 1'b1;
        end
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_q;
  logic        retire_evt;

  // An instruction retires when J resolves in DECODE or the datapath completes in EXEC
  always_comb begin
    retire_evt = ((state_q == ST_DECODE) && is_j) || ((state_q == ST_EXEC) && exec_done);
  end

  // Free-running retired count, wraps naturally at 32 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
    end else if (retire_evt) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl with an instruction-level reference model
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir;
  logic        stall;
  logic        exec_done;
  logic        redirect;
  logic [1:0]  redirect_sel;
  logic [1:0]  pc_sel;
  logic        pc_ld, pc_inc, im_cs, im_rd, im_wr, ir_ld, ir_valid, halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_ret = '0;

  fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .IR_in        (ir),
    .stall        (stall),
    .exec_done    (exec_done),
    .redirect     (redirect),
    .redirect_sel (redirect_sel),
    .pc_sel       (pc_sel),
    .pc_ld        (pc_ld),
    .pc_inc       (pc_inc),
    .im_cs        (im_cs),
    .im_rd        (im_rd),
    .im_wr        (im_wr),
    .ir_ld        (ir_ld),
    .ir_valid     (ir_valid),
    .halted       (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .retired      (retired)
`endif
  );

  always #5 clk = ~clk;

  // Output vector order: pc_sel[9:8] pc_ld pc_inc im_cs im_rd im_wr ir_ld ir_valid halted
  localparam logic [9:0] V_IDLE  = 10'b00_0_0_0_0_0_0_0_0;
  localparam logic [9:0] V_FETCH = 10'b00_0_1_1_1_0_1_0_0;
  localparam logic [9:0] V_DEC   = 10'b00_0_0_0_0_0_0_1_0;
  localparam logic [9:0] V_DJMP  = 10'b01_1_0_0_0_0_0_1_0;
  localparam logic [9:0] V_HALT  = 10'b00_0_0_0_0_0_0_0_1;

  function automatic logic [9:0] obs();
    return {pc_sel, pc_ld, pc_inc, im_cs, im_rd, im_wr, ir_ld, ir_valid, halted};
  endfunction

  task automatic check_out(input string tag, input logic [9:0] exp);
    logic [9:0] o;
    o = obs();
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, exp);
    end
  endtask

  task automatic check_ret(input string tag);
`ifdef FETCH_PERF_CNT_EN
    checks++;
    assert (retired === model_ret) else begin
      errors++;
      $error("FAIL %s retired observed=%h expected=%h", tag, retired, model_ret);
    end
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // One clock: check outputs mid-cycle, account for a retire, then advance past the edge
  task automatic cycle(input string tag, input logic [9:0] exp, input bit retire);
    @(negedge clk);
    check_out(tag, exp);
    if (retire) model_ret = model_ret + 32'd1;
    @(posedge clk);
    #1;
`ifdef FETCH_PERF_CNT_EN
    check_ret({tag, "_cnt"});
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_ret = '0;
    check_out("reset_async", V_IDLE);
    check_ret("reset_cnt");
    repeat (2) begin
      stall = 1'($urandom); exec_done = 1'($urandom); redirect = 1'($urandom);
      @(posedge clk);
      #1;
      check_out("reset_hold", V_IDLE);
    end
    reset = 1'b0;
    stall = 1'b0; exec_done = 1'b0; redirect = 1'b0;
    cycle("rst_wait", V_IDLE, 0);
  endtask

  // Runs one instruction from the FETCH state, computing each cycle's outputs from the instruction class
  task automatic run_instr(input logic [31:0] iw, input int nstall, input int nwait,
                           input bit redir, input logic [1:0] sel);
    logic [5:0] op;
    logic [5:0] fn;
    op = iw[31:26];
    fn = iw[5:0];
    for (int i = 0; i < nstall; i++) begin
      stall = 1'b1; exec_done = 1'($urandom); redirect = 1'($urandom); ir = $urandom;
      cycle("fetch_stall", V_IDLE, 0);
    end
    stall = 1'b0; exec_done = 1'($urandom); redirect = 1'($urandom); ir = $urandom;
    cycle("fetch", V_FETCH, 0);
    ir = iw; stall = 1'($urandom); exec_done = 1'($urandom); redirect = 1'($urandom);
    redirect_sel = 2'($urandom);
    if (op == 6'd2) begin
      cycle("dec_j", V_DJMP, 1);
      return;
    end
    if (op == 6'd3) begin
      cycle("dec_jal", V_DJMP, 0);
    end else if (op == 6'd0 && fn == 6'd13) begin
      cycle("dec_break", V_DEC, 0);
      repeat (4) begin
        stall = 1'($urandom); exec_done = 1'($urandom); redirect = 1'($urandom);
        cycle("halt", V_HALT, 0);
      end
      return;
    end else begin
      cycle("dec", V_DEC, 0);
    end
    for (int i = 0; i < nwait; i++) begin
      exec_done = 1'b0; redirect = 1'($urandom); stall = 1'($urandom);
      redirect_sel = 2'($urandom);
      cycle("exec_wait", V_IDLE, 0);
    end
    exec_done = 1'b1; redirect = redir; redirect_sel = sel; stall = 1'($urandom);
    cycle("exec_done", redir ? {sel, 8'h80} : V_IDLE, 1);
    exec_done = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    logic [31:0] iw;
    int          kind;
    reset = 1'b1; ir = '0; stall = 1'b0; exec_done = 1'b0; redirect = 1'b0; redirect_sel = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    run_instr(32'h08000010, 0, 0, 1'b0, 2'b00);  // J
    run_instr(32'h10000003, 0, 0, 1'b1, 2'b00);  // BEQ taken
    run_instr(32'h00851020, 3, 5, 1'b0, 2'b00);  // ADD with stall and slow exec
    run_instr(32'h0C000040, 0, 2, 1'b0, 2'b00);  // JAL
    run_instr(32'h03E00008, 1, 0, 1'b1, 2'b10);  // JR

`ifdef FETCH_PERF_CNT_EN
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    model_ret = 32'hFFFF_FFFF;
    check_ret("cnt_preset");
    run_instr(32'h08000004, 0, 0, 1'b0, 2'b00);  // retire wraps to 0
`endif

    run_instr(32'h0000000D, 0, 0, 1'b0, 2'b00);  // BREAK
    do_reset();

    // Reset asserted mid-EXEC with completion pending must discard the instruction
    run_instr(32'h08000020, 0, 0, 1'b0, 2'b00);
    stall = 1'b0;
    cycle("fetch_pre_rst", V_FETCH, 0);
    ir = 32'h20010005;
    cycle("dec_pre_rst", V_DEC, 0);
    exec_done = 1'b1; redirect = 1'b1; redirect_sel = 2'b10;
    @(negedge clk);
    check_out("exec_pre_rst", 10'b10_1_0_0_0_0_0_0_0);
    reset = 1'b1;
    #1;
    model_ret = '0;
    check_out("rst_in_exec", V_IDLE);
    check_ret("rst_in_exec_cnt");
    @(posedge clk);
    #1;
    reset = 1'b0; exec_done = 1'b0; redirect = 1'b0;
    cycle("rst_wait_exec", V_IDLE, 0);

    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        iw = {6'd2, 26'($urandom)};
      end else if (kind == 1) begin
        iw = {6'd3, 26'($urandom)};
      end else if (kind == 2) begin
        iw = {6'd0, 20'($urandom), 6'd13};
      end else begin
        iw = $urandom;
        for (int k = 0; k < 20; k++) begin
          if (iw[31:26] == 6'd2 || iw[31:26] == 6'd3 || (iw[31:26] == 6'd0 && iw[5:0] == 6'd13))
            iw = $urandom;
        end
        if (iw[31:26] == 6'd2 || iw[31:26] == 6'd3 || iw[31:26] == 6'd0) iw[31:26] = 6'd4;
      end
      run_instr(iw, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                1'($urandom), 2'($urandom));
      if (kind == 2) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
